// File: rtl/baro_packetizer.sv
// Barometric sensor packetizer: snapshots PROM coefficients and ADC result
// on a conversion trigger and streams a framed, checksummed byte packet.
module baro_packetizer #(
    parameter logic [7:0] HDR0      = 8'hA5,
    parameter logic [7:0] HDR1      = 8'h5A,
    parameter logic [7:0] DATA_TYPE = 8'h01,
    parameter logic [7:0] ERR_TYPE  = 8'hE1,
    parameter bit         PROM_EN   = 1'b1
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic [15:0] prom_data0,
    input  logic [15:0] prom_data1,
    input  logic [15:0] prom_data2,
    input  logic [15:0] prom_data3,
    input  logic [15:0] prom_data4,
    input  logic [23:0] adc_data,
    input  logic        data_ok,
    input  logic        i2c_error,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [7:0]  seq_num,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_TYPE,
        S_SEQ,
        S_PAYLOAD,
        S_CSUM
    } state_t;

    localparam logic [3:0] LAST_IDX = PROM_EN ? 4'd12 : 4'd2;

    state_t      r_state;
    logic        r_ok_q;
    logic        r_err_q;
    logic [15:0] r_c1, r_c2, r_c3, r_c4, r_c5;
    logic [23:0] r_adc;
    logic        r_is_err;
    logic [3:0]  r_idx;
    logic [7:0]  r_sum;
    logic [7:0]  r_data;
    logic        r_valid;
    logic [7:0]  r_seq;
    logic [7:0]  r_drop;

    state_t      w_state_nxt;
    logic        w_is_err_nxt;
    logic [3:0]  w_idx_nxt;
    logic [7:0]  w_sum_nxt;
    logic [7:0]  w_data_nxt;
    logic        w_valid_nxt;
    logic [7:0]  w_seq_nxt;
    logic [7:0]  w_drop_nxt;
    logic        w_cap;
    logic        w_ok_rise;
    logic        w_err_rise;
    logic        w_trig;
    logic        w_acc;
    logic [7:0]  w_sum_add;
    logic [3:0]  w_pay_sel;
    logic [7:0]  w_pay_byte;

    assign w_ok_rise  = data_ok & ~r_ok_q;
    assign w_err_rise = i2c_error & ~r_err_q;
    assign w_trig     = w_ok_rise | w_err_rise;
    assign w_acc      = r_valid & out_ready;
    assign w_sum_add  = r_sum + r_data;
    assign w_pay_sel  = (r_state == S_SEQ) ? 4'd0 : r_idx + 4'd1;

    // Payload byte selected for loading on the next accepted byte
    always_comb begin
        w_pay_byte = '0;
        if (PROM_EN) begin
            case (w_pay_sel)
                4'd0:    w_pay_byte = r_c1[15:8];
                4'd1:    w_pay_byte = r_c1[7:0];
                4'd2:    w_pay_byte = r_c2[15:8];
                4'd3:    w_pay_byte = r_c2[7:0];
                4'd4:    w_pay_byte = r_c3[15:8];
                4'd5:    w_pay_byte = r_c3[7:0];
                4'd6:    w_pay_byte = r_c4[15:8];
                4'd7:    w_pay_byte = r_c4[7:0];
                4'd8:    w_pay_byte = r_c5[15:8];
                4'd9:    w_pay_byte = r_c5[7:0];
                4'd10:   w_pay_byte = r_adc[23:16];
                4'd11:   w_pay_byte = r_adc[15:8];
                4'd12:   w_pay_byte = r_adc[7:0];
                default: w_pay_byte = '0;
            endcase
        end else begin
            case (w_pay_sel)
                4'd0:    w_pay_byte = r_adc[23:16];
                4'd1:    w_pay_byte = r_adc[15:8];
                4'd2:    w_pay_byte = r_adc[7:0];
                default: w_pay_byte = '0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_is_err_nxt = r_is_err;
        w_idx_nxt    = r_idx;
        w_sum_nxt    = r_sum;
        w_data_nxt   = r_data;
        w_valid_nxt  = r_valid;
        w_seq_nxt    = r_seq;
        w_drop_nxt   = r_drop;
        w_cap        = 1'b0;

        if (w_trig && r_state != S_IDLE && r_drop != 8'hFF)
            w_drop_nxt = r_drop + 8'd1;

        unique case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_cap        = 1'b1;
                    w_is_err_nxt = w_err_rise;
                    w_sum_nxt    = '0;
                    w_data_nxt   = HDR0;
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = S_HDR0;
                end
            end
            S_HDR0: begin
                if (w_acc) begin
                    w_data_nxt  = HDR1;
                    w_state_nxt = S_HDR1;
                end
            end
            S_HDR1: begin
                if (w_acc) begin
                    w_data_nxt  = r_is_err ? ERR_TYPE : DATA_TYPE;
                    w_state_nxt = S_TYPE;
                end
            end
            S_TYPE: begin
                if (w_acc) begin
                    w_sum_nxt   = w_sum_add;
                    w_data_nxt  = r_seq;
                    w_state_nxt = S_SEQ;
                end
            end
            S_SEQ: begin
                if (w_acc) begin
                    w_sum_nxt = w_sum_add;
                    if (r_is_err) begin
                        w_data_nxt  = w_sum_add;
                        w_state_nxt = S_CSUM;
                    end else begin
                        w_idx_nxt   = '0;
                        w_data_nxt  = w_pay_byte;
                        w_state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_acc) begin
                    w_sum_nxt = w_sum_add;
                    if (r_idx == LAST_IDX) begin
                        w_data_nxt  = w_sum_add;
                        w_state_nxt = S_CSUM;
                    end else begin
                        w_idx_nxt  = r_idx + 4'd1;
                        w_data_nxt = w_pay_byte;
                    end
                end
            end
            S_CSUM: begin
                if (w_acc) begin
                    w_data_nxt  = '0;
                    w_valid_nxt = 1'b0;
                    w_seq_nxt   = r_seq + 8'd1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_ok_q   <= 1'b0;
            r_err_q  <= 1'b0;
            r_c1     <= '0;
            r_c2     <= '0;
            r_c3     <= '0;
            r_c4     <= '0;
            r_c5     <= '0;
            r_adc    <= '0;
            r_is_err <= 1'b0;
            r_idx    <= '0;
            r_sum    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_seq    <= '0;
            r_drop   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ok_q   <= data_ok;
            r_err_q  <= i2c_error;
            r_is_err <= w_is_err_nxt;
            r_idx    <= w_idx_nxt;
            r_sum    <= w_sum_nxt;
            r_data   <= w_data_nxt;
            r_valid  <= w_valid_nxt;
            r_seq    <= w_seq_nxt;
            r_drop   <= w_drop_nxt;
            if (w_cap) begin
                r_c1  <= prom_data0;
                r_c2  <= prom_data1;
                r_c3  <= prom_data2;
                r_c4  <= prom_data3;
                r_c5  <= prom_data4;
                r_adc <= adc_data;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign busy      = (r_state != S_IDLE);
    assign seq_num   = r_seq;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_baro_packetizer.sv
// Bench for baro_packetizer: directed scenarios plus random packets
// checked against a byte-list packet model.
module tb_baro_packetizer;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic [15:0] prom_data0, prom_data1, prom_data2, prom_data3, prom_data4;
    logic [23:0] adc_data;
    logic        data_ok, i2c_error;
    logic [7:0]  out_data;
    logic        out_valid, out_ready, busy;
    logic [7:0]  seq_num, drop_cnt;

    always #5 clk_in = ~clk_in;

    baro_packetizer #(.PROM_EN(1'b1)) dut (
        .clk_in(clk_in), .reset_n(reset_n),
        .prom_data0(prom_data0), .prom_data1(prom_data1),
        .prom_data2(prom_data2), .prom_data3(prom_data3),
        .prom_data4(prom_data4), .adc_data(adc_data),
        .data_ok(data_ok), .i2c_error(i2c_error),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .seq_num(seq_num), .drop_cnt(drop_cnt)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] m_c [5];
    logic [23:0] m_adc;
    logic [7:0]  m_seq;
    logic [7:0]  exp_q [$];
    logic [7:0]  rx_q [$];
    int          got;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packet as a plain byte list: header, type, seq, payload, sum
    task automatic make_pkt(input bit err);
        logic [7:0] s;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(err ? 8'hE1 : 8'h01);
        exp_q.push_back(m_seq);
        if (!err) begin
            for (int i = 0; i < 5; i++) begin
                exp_q.push_back(m_c[i][15:8]);
                exp_q.push_back(m_c[i][7:0]);
            end
            exp_q.push_back(m_adc[23:16]);
            exp_q.push_back(m_adc[15:8]);
            exp_q.push_back(m_adc[7:0]);
        end
        s = 8'h00;
        for (int i = 2; i < exp_q.size(); i++) s = s + exp_q[i];
        exp_q.push_back(s);
    endtask

    task automatic scramble();
        prom_data0 = 16'($urandom);
        prom_data1 = 16'($urandom);
        prom_data2 = 16'($urandom);
        prom_data3 = 16'($urandom);
        prom_data4 = 16'($urandom);
        adc_data   = 24'($urandom);
    endtask

    task automatic trig(input bit dk, input bit ek);
        @(negedge clk_in);
        data_ok = 1'b0;
        i2c_error = 1'b0;
        @(negedge clk_in);
        check("idle_busy", busy, 0);
        prom_data0 = m_c[0];
        prom_data1 = m_c[1];
        prom_data2 = m_c[2];
        prom_data3 = m_c[3];
        prom_data4 = m_c[4];
        adc_data   = m_adc;
        data_ok    = dk;
        i2c_error  = ek;
        @(posedge clk_in);
        #1;
        check("latency_valid", out_valid, 1);
        check("first_byte", out_data, 8'hA5);
        scramble();
    endtask

    task automatic recv(input int mode, input int n);
        bit         pv, pr;
        logic [7:0] pd;
        int         cyc;
        got = 0;
        pv = 0;
        pr = 0;
        pd = 0;
        cyc = 0;
        rx_q.delete();
        while (got < n && cyc < 400) begin
            @(negedge clk_in);
            cyc++;
            if (pv && !pr) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold", out_data, pd);
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 1) || (cyc % 4 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) begin
                check("byte", out_data, exp_q[got]);
                rx_q.push_back(out_data);
                got++;
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
        end
        check("byte_count", got, n);
    endtask

    task automatic finish_pkt(input int mode);
        recv(mode, exp_q.size());
        @(negedge clk_in);
        check("end_valid", out_valid, 0);
        check("end_busy", busy, 0);
        m_seq++;
        check("seq_num", seq_num, m_seq);
    endtask

    task automatic send(input bit dk, input bit ek, input int mode);
        make_pkt(ek);
        trig(dk, ek);
        finish_pkt(mode);
    endtask

    task automatic set_t1();
        m_c[0] = 16'h1234;
        m_c[1] = 16'h0;
        m_c[2] = 16'h0;
        m_c[3] = 16'h0;
        m_c[4] = 16'h0;
        m_adc  = 24'h000102;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        data_ok = 1'b0;
        i2c_error = 1'b0;
        out_ready = 1'b0;
        scramble();
        m_seq = 8'h00;
        repeat (2) @(negedge clk_in);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_seq", seq_num, 0);
        check("rst_drop", drop_cnt, 0);
        reset_n = 1'b1;

        set_t1();
        send(1'b1, 1'b0, 0);
        check("t1_c1hi", rx_q[4], 8'h12);
        check("t1_csum", rx_q[17], 8'h4A);

        send(1'b0, 1'b1, 0);
        check("err_len", rx_q.size(), 5);
        check("err_csum", rx_q[4], 8'hE2);

        set_t1();
        send(1'b1, 1'b0, 1);

        send(1'b1, 1'b1, 0);
        check("both_len", rx_q.size(), 5);
        check("both_drop", drop_cnt, 0);
        repeat (4) begin
            @(negedge clk_in);
            check("no_retrig", out_valid, 0);
        end

        set_t1();
        make_pkt(1'b0);
        trig(1'b1, 1'b0);
        fork
            recv(0, exp_q.size());
            begin
                repeat (5) @(negedge clk_in);
                data_ok = 1'b0;
                adc_data = 24'hFFFFFF;
                @(negedge clk_in);
                data_ok = 1'b1;
            end
        join
        check("drop_adc", {rx_q[14], rx_q[15], rx_q[16]}, 24'h000102);
        @(negedge clk_in);
        check("drop_end_valid", out_valid, 0);
        m_seq++;
        check("drop_seq", seq_num, m_seq);
        check("drop_one", drop_cnt, 1);

        m_c[0] = 16'hBEEF;
        m_adc  = 24'hC0FFEE;
        make_pkt(1'b0);
        out_ready = 1'b0;
        trig(1'b1, 1'b0);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk_in);
            if (i == 10) check("drop_mid", drop_cnt, 11);
            data_ok = 1'b0;
            @(negedge clk_in);
            data_ok = 1'b1;
        end
        @(negedge clk_in);
        check("drop_sat", drop_cnt, 8'hFF);
        check("sat_hold_valid", out_valid, 1);
        check("sat_hold_data", out_data, 8'hA5);
        finish_pkt(2);

        for (int i = 0; i < 5; i++) m_c[i] = 16'($urandom);
        m_adc = 24'($urandom);
        make_pkt(1'b0);
        trig(1'b1, 1'b0);
        recv(0, 7);
        @(negedge clk_in);
        reset_n = 1'b0;
        data_ok = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_seq", seq_num, 0);
        check("mid_rst_drop", drop_cnt, 0);
        m_seq = 8'h00;
        @(negedge clk_in);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk_in);
            check("post_rst_idle", out_valid, 0);
        end
        send(1'b1, 1'b0, 0);
        check("post_rst_seq", rx_q[3], 8'h00);

        for (int p = 0; p < 8; p++) begin
            bit e;
            e = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 5; i++) m_c[i] = 16'($urandom);
            m_adc = 24'($urandom);
            send(!e, e, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/baro_packetizer.md
Name: baro_packetizer

Overview:
Sits directly downstream of the barometric-sensor I2C sequencer, on the same clock. On each completed conversion, it snapshots the five PROM coefficients and the 24-bit ADC result. It then serializes them as a framed, checksummed byte packet over a valid/ready byte stream into the USB FIFO writer. An I2C-error event produces a short error packet instead.

Parameters:
HDR0, 8'hA5, first header byte
HDR1, 8'h5A, second header byte
DATA_TYPE, 8'h01, type byte of a data packet
ERR_TYPE, 8'hE1, type byte of an error packet
PROM_EN, 1, 1 = include the 10 PROM bytes in data packets; 0 = ADC bytes only

Ports:
clk_in  input  1  system clock (same clock as the I2C sequencer)
reset_n  input  1  asynchronous active-low reset
prom_data0..prom_data4  input  16 each  coefficients C1..C5
adc_data  input  24  ADC conversion result
data_ok  input  1  level; rises once per completed conversion
i2c_error  input  1  level; rises when the sequencer enters its error state
out_data  output  8  stream byte
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts the byte this cycle
busy  output  1  high whenever state != IDLE
seq_num  output  8  sequence number of the next packet
drop_cnt  output  8  saturating count of dropped triggers

Behaviour:
- Reset (async, any state): state=IDLE; out_data=0; out_valid=0; busy=0; seq_num=0; drop_cnt=0; edge registers=0; snapshot=0.
- Edge detect: one register each for data_ok and i2c_error. A trigger is the rising edge: current value is 1 and the registered value is 0.
- States: IDLE, HDR0, HDR1, TYPE, SEQ, PAYLOAD, CSUM.
- Trigger sampled while in IDLE:
  - The snapshot (prom_data0..4, adc_data) is captured on that same edge.
  - The packet kind (data or error) is latched.
  - state goes to HDR0, out_valid=1, out_data=HDR0, all registered from that edge. Latency is one cycle from the trigger edge to out_valid.
- Both triggers on the same edge: the error packet wins and the data trigger is discarded. This is not counted as a drop.
- Byte advance: the next byte is loaded only on an edge where out_valid && out_ready. While out_valid && !out_ready, out_data is held stable.
- Byte order: HDR0, HDR1, TYPE (DATA_TYPE or ERR_TYPE), SEQ (= seq_num), PAYLOAD, CSUM.
- PAYLOAD for a data packet, MSB first:
  - PROM_EN=1: C1[15:8], C1[7:0] … C5[15:8], C5[7:0], then adc[23:16], adc[15:8], adc[7:0] (13 bytes).
  - PROM_EN=0: the three ADC bytes only.
- An error packet has no PAYLOAD; SEQ is followed directly by CSUM.
- Payload byte index uses a 4-bit counter that is cleared on entering PAYLOAD.
- CSUM = 8-bit modular sum of TYPE, SEQ and all payload bytes. Header bytes are excluded. The sum is accumulated as bytes are accepted.
- On acceptance of CSUM:
  - state goes to IDLE, out_valid=0.
  - seq_num increments, wrapping 8'hFF to 8'h00.
- Packet length: data packet is 18 bytes (PROM_EN=1) or 8 bytes (PROM_EN=0); error packet is 5 bytes.
- A trigger sampled in any state other than IDLE (including the edge that accepts CSUM):
  - The trigger is dropped.
  - drop_cnt increments, saturating at 8'hFF.
  - The in-flight packet and its snapshot are unaffected.
- Levels that stay high do not retrigger. A new trigger requires the input to fall and rise again.
- Reset asserted mid-packet: the packet is abandoned with no tail bytes. After release the block waits in IDLE for a fresh edge.

Test Plan:
- PROM_EN=1, C1=16'h1234, C2..C5=0, adc=24'h000102, out_ready=1, data_ok rise → one cycle later out_valid=1; 18 consecutive bytes A5 5A 01 00 12 34 00×8 00 01 02 4A; seq_num becomes 1.
- i2c_error rise in IDLE with seq_num=0 → 5 bytes A5 5A E1 00 E1; seq_num becomes 1.
- Data packet with out_ready toggled 1,0,0,1 pattern → out_data constant during every stall; byte stream identical to the first scenario; no byte duplicated or skipped.
- data_ok re-rise mid-packet while adc_data changes to 24'hFFFFFF → drop_cnt=1; emitted ADC bytes remain 00 01 02; 256 further mid-packet triggers → drop_cnt saturates at FF.
- data_ok and i2c_error rising on the same edge → only the error packet (5 bytes) is emitted; drop_cnt unchanged.
- reset_n pulsed low at byte 7 → out_valid=0 immediately and all outputs at reset values; the next data_ok rise yields a full packet with SEQ=00.
